alu_sequencer: RTL and testbench

Multi-cycle control unit that turns the 8-bit ALU into a small stored-program CPU.
- Fetches 8-bit instructions from a synchronous instruction memory and reads operands from a 4×8 register file.
- Drives the ALU (a, b, 3-bit select), then writes back alu_out and carry_out.
- Sits between the instruction memory and the combinational ALU; a host starts it and is told when it is done.

---
 rtl/alu_seq_pkg.sv | 57 +++++
 rtl/alu_seq_regfile.sv | 48 ++++
 rtl/alu_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU sequencer.
//   - alu_op_e   : 3-bit ALU opcodes driven on alu_sel (OP_ADD .. OP_COMP)
//   - state_e    : sequencer FSM state encoding
//   - HALT_INSTR : the all-zero instruction word that stops the program
//   - IR_*       : instruction field bit positions, plus field extractors
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MUL  = 3'd5,
    OP_DIV  = 3'd6,
    OP_COMP = 3'd7
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  localparam logic [7:0] HALT_INSTR = 8'h00;

  // Instruction layout: [7:5] opcode, [4:3] rd (source A and destination),
  // [2:1] rs (source B), [0] save.
  localparam int IR_OP_MSB = 7;
  localparam int IR_OP_LSB = 5;
  localparam int IR_RD_MSB = 4;
  localparam int IR_RD_LSB = 3;
  localparam int IR_RS_MSB = 2;
  localparam int IR_RS_LSB = 1;
  localparam int IR_SAVE   = 0;

  function automatic alu_op_e instr_op(input logic [7:0] ins);
    return alu_op_e'(ins[IR_OP_MSB:IR_OP_LSB]);
  endfunction

  function automatic logic [1:0] instr_rd(input logic [7:0] ins);
    return ins[IR_RD_MSB:IR_RD_LSB];
  endfunction

  function automatic logic [1:0] instr_rs(input logic [7:0] ins);
    return ins[IR_RS_MSB:IR_RS_LSB];
  endfunction

  function automatic logic instr_save(input logic [7:0] ins);
    return ins[IR_SAVE];
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile
// Four 8-bit general registers with two asynchronous read ports and one
// synchronous write port. All entries clear on reset.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   we, waddr, wdata    : write strobe, index and value (takes effect at clk)
//   raddr_a / rdata_a   : read port A (combinational)
//   raddr_b / rdata_b   : read port B (combinational)
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] regs [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_entry
      logic [7:0] entry_d;
      logic [7:0] entry_q;

      assign entry_d = (we && (waddr == 2'(gi))) ? wdata : entry_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign regs[gi] = entry_q;
    end
  endgenerate

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Multi-cycle control unit that runs a short program from a synchronous
// instruction memory on an external combinational 8-bit ALU.
// Each non-HALT instruction takes FETCH, DECODE, EXECUTE, WRITEBACK;
// a HALT takes FETCH, DECODE, then DONE. Execution also stops after the
// instruction at PROG_LEN-1 (pc never wraps).
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   start                          : run from address 0 (IDLE only)
//   load_en, load_addr, load_data  : register-file preload (IDLE only)
//   imem_addr / imem_data          : instruction fetch, data one cycle later
//   alu_a, alu_b, alu_sel          : ALU operands/opcode, zero outside EXECUTE
//   alu_out, carry_out             : ALU result and flag
//   data_out, carry_flag           : last saved result and its carry
//   busy                           : high whenever not IDLE
//   done                           : one-cycle pulse when the program halts
// Optional build macro PERF_CNT_EN adds instr_count and cycle_count
// (saturating 16-bit counters, cleared on reset and on an accepted start).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PC_W     = 4,
  parameter int PROG_LEN = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            load_en,
  input  logic [1:0]      load_addr,
  input  logic [7:0]      load_data,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  output logic [2:0]      alu_sel,
  input  logic [7:0]      alu_out,
  input  logic            carry_out,
  output logic [7:0]      data_out,
  output logic            carry_flag,
  output logic            busy,
`ifdef PERF_CNT_EN
  output logic [15:0]     instr_count,
  output logic [15:0]     cycle_count,
`endif
  output logic            done
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic [7:0]      res_q, res_d;
  logic            res_c_q, res_c_d;
  logic [7:0]      data_out_q, data_out_d;
  logic            carry_flag_q, carry_flag_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  alu_op_e         alu_sel_q, alu_sel_d;

  logic            rf_we;
  logic [1:0]      rf_waddr;
  logic [7:0]      rf_wdata;
  logic [7:0]      rf_rd_data;
  logic [7:0]      rf_rs_data;

  // Preloads only land in IDLE; result write-back only in WRITEBACK with
  // the save bit set. The two cases are mutually exclusive by state.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = instr_rd(ir_q);
    rf_wdata = res_q;
    if (state_q == ST_IDLE) begin
      rf_we    = load_en;
      rf_waddr = load_addr;
      rf_wdata = load_data;
    end else if (state_q == ST_WRITEBACK) begin
      rf_we    = instr_save(ir_q);
    end
  end

  // Read ports are addressed from ir_d so that operands can be registered
  // on the DECODE->EXECUTE edge, in step with the instruction itself.
  alu_seq_regfile u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (instr_rd(ir_d)),
    .rdata_a (rf_rd_data),
    .raddr_b (instr_rs(ir_d)),
    .rdata_b (rf_rs_data)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    res_d        = res_q;
    res_c_d      = res_c_q;
    data_out_d   = data_out_q;
    carry_flag_d = carry_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d    = imem_data;
        state_d = (imem_data == HALT_INSTR) ? ST_DONE : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        res_d   = alu_out;
        res_c_d = carry_out;
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        if (instr_save(ir_q)) begin
          data_out_d   = res_q;
          carry_flag_d = res_c_q;
        end
        if (pc_q == LAST_PC) begin
          state_d = ST_DONE;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status and ALU drive are decoded from the next state so they are
    // registered yet line up with the state they describe.
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    alu_a_d   = (state_d == ST_EXECUTE) ? rf_rd_data : 8'h00;
    alu_b_d   = (state_d == ST_EXECUTE) ? rf_rs_data : 8'h00;
    alu_sel_d = (state_d == ST_EXECUTE) ? instr_op(ir_d) : OP_ADD;
  end

`ifdef PERF_CNT_EN
  logic [15:0] instr_count_q, instr_count_d;
  logic [15:0] cycle_count_q, cycle_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    cycle_count_d = cycle_count_q;
    if (state_q == ST_IDLE && start) begin
      instr_count_d = '0;
      cycle_count_d = '0;
    end else begin
      if (state_q == ST_WRITEBACK && instr_count_q != 16'hFFFF) begin
        instr_count_d = instr_count_q + 16'd1;
      end
      // busy_q mirrors the current state, so this counts busy cycles.
      if (busy_q && cycle_count_q != 16'hFFFF) begin
        cycle_count_d = cycle_count_q + 16'd1;
      end
    end
  end

  assign instr_count = instr_count_q;
  assign cycle_count = cycle_count_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      res_q        <= '0;
      res_c_q      <= 1'b0;
      data_out_q   <= '0;
      carry_flag_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= OP_ADD;
`ifdef PERF_CNT_EN
      instr_count_q <= '0;
      cycle_count_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      res_q        <= res_d;
      res_c_q      <= res_c_d;
      data_out_q   <= data_out_d;
      carry_flag_q <= carry_flag_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
`ifdef PERF_CNT_EN
      instr_count_q <= instr_count_d;
      cycle_count_q <= cycle_count_d;
`endif
    end
  end

  assign imem_addr  = pc_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign data_out   = data_out_q;
  assign carry_flag = carry_flag_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
// Two sequencer instances share stimulus: u_dut16 (PROG_LEN=16) and
// u_dut2 (PROG_LEN=2). sel1 picks which one is observed; the bench resets
// both whenever it switches. The reference model walks each program
// instruction by instruction and predicts, per cycle, busy/done, the ALU
// drive, data_out and carry_flag.
module tb_alu_sequencer;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       start     = 1'b0;
  logic       load_en   = 1'b0;
  logic [1:0] load_addr = 2'd0;
  logic [7:0] load_data = 8'd0;

  always #5 clk = ~clk;

  logic [7:0] prog [16];

  // ALU behaviour supplied by the bench (the sequencer only passes it on).
  function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] p;
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {(a < b), 8'(a - b)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: begin
        p = {8'd0, a} * {8'd0, b};
        return {|p[15:8], p[7:0]};
      end
      3'd6: return (b == 8'd0) ? 9'h1FF : {1'b0, 8'(a / b)};
      default: return {(a > b), 7'd0, (a == b)};
    endcase
  endfunction

  // ---------------- instance with PROG_LEN = 16 ----------------
  logic [3:0] imem_addr0;
  logic [7:0] imem_data0, alu_a0, alu_b0, alu_out0, data_out0;
  logic [2:0] alu_sel0;
  logic       carry_out0, carry_flag0, busy0, done0;
`ifdef PERF_CNT_EN
  logic [15:0] ic0, cc0;
`endif
  always @(posedge clk) imem_data0 <= prog[imem_addr0];
  assign {carry_out0, alu_out0} = alu_ref(alu_sel0, alu_a0, alu_b0);

  alu_sequencer #(.PC_W(4), .PROG_LEN(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data),
    .imem_addr(imem_addr0), .imem_data(imem_data0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_sel0),
    .alu_out(alu_out0), .carry_out(carry_out0),
    .data_out(data_out0), .carry_flag(carry_flag0), .busy(busy0),
`ifdef PERF_CNT_EN
    .instr_count(ic0), .cycle_count(cc0),
`endif
    .done(done0)
  );

  // ---------------- instance with PROG_LEN = 2 ----------------
  logic [3:0] imem_addr1;
  logic [7:0] imem_data1, alu_a1, alu_b1, alu_out1, data_out1;
  logic [2:0] alu_sel1;
  logic       carry_out1, carry_flag1, busy1, done1;
`ifdef PERF_CNT_EN
  logic [15:0] ic1, cc1;
`endif
  always @(posedge clk) imem_data1 <= prog[imem_addr1];
  assign {carry_out1, alu_out1} = alu_ref(alu_sel1, alu_a1, alu_b1);

  alu_sequencer #(.PC_W(4), .PROG_LEN(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data),
    .imem_addr(imem_addr1), .imem_data(imem_data1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
    .alu_out(alu_out1), .carry_out(carry_out1),
    .data_out(data_out1), .carry_flag(carry_flag1), .busy(busy1),
`ifdef PERF_CNT_EN
    .instr_count(ic1), .cycle_count(cc1),
`endif
    .done(done1)
  );

  // ---------------- observed instance ----------------
  bit         sel1 = 1'b0;
  logic [31:0] obs;
  logic [3:0]  addr_s;
`ifdef PERF_CNT_EN
  logic [15:0] ic_s, cc_s;
`endif
  always_comb begin
    if (sel1) begin
      obs    = {2'b00, busy1, done1, alu_a1, alu_b1, alu_sel1, data_out1, carry_flag1};
      addr_s = imem_addr1;
    end else begin
      obs    = {2'b00, busy0, done0, alu_a0, alu_b0, alu_sel0, data_out0, carry_flag0};
      addr_s = imem_addr0;
    end
`ifdef PERF_CNT_EN
    ic_s = sel1 ? ic1 : ic0;
    cc_s = sel1 ? cc1 : cc0;
`endif
  end

  // ---------------- reference model state ----------------
  logic [7:0] m_rf [4];
  logic [7:0] m_dout;
  logic       m_cf;
  int         plen;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  function automatic logic [31:0] exp_vec(input bit b, input bit d, input logic [7:0] a,
                                          input logic [7:0] bb, input logic [2:0] s);
    return {2'b00, b, d, a, bb, s, m_dout, m_cf};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
    m_dout = 8'd0;
    m_cf   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step();
    check_eq("reset_state", obs, exp_vec(1'b0, 1'b0, 8'd0, 8'd0, 3'd0));
  endtask

  task automatic preload(input logic [1:0] a, input logic [7:0] v);
    load_en = 1'b1; load_addr = a; load_data = v;
    step();
    load_en = 1'b0;
    m_rf[a] = v;
  endtask

  // Runs prog[] from address 0. Optionally a preload rides with start, and
  // optionally start+load are pulsed again while busy (must be ignored).
  task automatic run_prog(input string name, input bit poke, input bit ld,
                          input logic [1:0] la, input logic [7:0] lv);
    int pc, ncyc, nwb;
    logic [7:0] ins;
    logic [8:0] r;
    start = 1'b1;
    if (ld) begin
      load_en = 1'b1; load_addr = la; load_data = lv;
      m_rf[la] = lv;
    end
    step();
    start = 1'b0; load_en = 1'b0;
    pc = 0; ncyc = 0; nwb = 0;
    forever begin
      ncyc++;
      check_eq({name, "_fetch"}, obs, exp_vec(1'b1, 1'b0, 8'd0, 8'd0, 3'd0));
      check_eq({name, "_imem_addr"}, {28'd0, addr_s}, 32'(pc));
      if (poke && pc == 0) begin
        start = 1'b1; load_en = 1'b1; load_addr = 2'd2; load_data = 8'd9;
      end
      step();
      start = 1'b0; load_en = 1'b0;
      ncyc++;
      check_eq({name, "_decode"}, obs, exp_vec(1'b1, 1'b0, 8'd0, 8'd0, 3'd0));
      ins = prog[pc];
      step();
      if (ins == 8'h00) break;
      ncyc++;
      check_eq({name, "_execute"}, obs,
               exp_vec(1'b1, 1'b0, m_rf[ins[4:3]], m_rf[ins[2:1]], ins[7:5]));
      r = alu_ref(ins[7:5], m_rf[ins[4:3]], m_rf[ins[2:1]]);
      step();
      ncyc++;
      check_eq({name, "_writeback"}, obs, exp_vec(1'b1, 1'b0, 8'd0, 8'd0, 3'd0));
      if (ins[0]) begin
        m_rf[ins[4:3]] = r[7:0];
        m_dout         = r[7:0];
        m_cf           = r[8];
      end
      nwb++;
      step();
      if (pc == plen - 1) break;
      pc++;
    end
    ncyc++;
    check_eq({name, "_done"}, obs, exp_vec(1'b1, 1'b1, 8'd0, 8'd0, 3'd0));
    step();
    check_eq({name, "_idle"}, obs, exp_vec(1'b0, 1'b0, 8'd0, 8'd0, 3'd0));
`ifdef PERF_CNT_EN
    check_eq({name, "_instr_count"}, {16'd0, ic_s}, 32'(nwb));
    check_eq({name, "_cycle_count"}, {16'd0, cc_s}, 32'(ncyc));
`endif
    $display("run %s: %0d instr, %0d cycles, data_out=%0d", name, nwb, ncyc, m_dout);
  endtask

  // Reads every register through the EXECUTE operand ports (OR r,r, no save).
  task automatic dump_regs();
    int chunk;
    logic [1:0] rr;
    chunk = (plen >= 5) ? 4 : plen;
    for (int base = 0; base < 4; base += chunk) begin
      for (int i = 0; i < chunk; i++) begin
        rr = 2'(base + i);
        prog[i] = {3'b011, rr, rr, 1'b0};
      end
      if (chunk < plen) prog[chunk] = 8'h00;
      run_prog("dump", 1'b0, 1'b0, 2'd0, 8'd0);
    end
  endtask

  task automatic random_prog(input bit poke);
    int len;
    len = $urandom_range(1, plen);
    for (int i = 0; i < len; i++) begin
      prog[i] = 8'($urandom_range(1, 255));
    end
    if (len < plen) prog[len] = 8'h00;
    run_prog("rand", poke, 1'b0, 2'd0, 8'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    plen = 16;
    sel1 = 1'b0;
    do_reset();

    // add with save=0: nothing written, ALU sees 5,3,add in EXECUTE only
    preload(2'd0, 8'd5);
    preload(2'd1, 8'd3);
    prog[0] = 8'h02; prog[1] = 8'h00;
    run_prog("add_nosave", 1'b0, 1'b0, 2'd0, 8'd0);
    dump_regs();

    // add r0,r1 with save
    prog[0] = 8'h03; prog[1] = 8'h00;
    run_prog("add_save", 1'b0, 1'b0, 2'd0, 8'd0);
    dump_regs();

    // sub then mul; r1 preload rides on the start cycle
    preload(2'd0, 8'd5);
    prog[0] = 8'h23; prog[1] = 8'hA3; prog[2] = 8'h00;
    run_prog("sub_mul", 1'b0, 1'b1, 2'd1, 8'd3);

    // start/load pulsed while busy must be ignored (r2 untouched)
    prog[0] = 8'h03; prog[1] = 8'h00;
    run_prog("busy_poke", 1'b1, 1'b0, 2'd0, 8'd0);
    dump_regs();

    // randomized programs and preloads, including full-length implicit halt
    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1) preload(2'(k), 8'($urandom_range(0, 255)));
      end
      random_prog(($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 16; i++) prog[i] = 8'h03;
    run_prog("full16", 1'b0, 1'b0, 2'd0, 8'd0);
    dump_regs();

    // reset in the middle of EXECUTE
    preload(2'd0, 8'd5);
    preload(2'd1, 8'd3);
    prog[0] = 8'h03; prog[1] = 8'h00;
    run_prog("pre_reset", 1'b0, 1'b0, 2'd0, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_eq("mid_exec_before", obs, exp_vec(1'b1, 1'b0, 8'd8, 8'd3, 3'd0));
    reset = 1'b1;
    #1;
    model_reset();
    check_eq("mid_exec_reset", obs, exp_vec(1'b0, 1'b0, 8'd0, 8'd0, 3'd0));
    @(negedge clk);
    reset = 1'b0;
    step();
    check_eq("after_reset", obs, exp_vec(1'b0, 1'b0, 8'd0, 8'd0, 3'd0));
    dump_regs();
    preload(2'd0, 8'd5);
    preload(2'd1, 8'd3);
    prog[0] = 8'h03; prog[1] = 8'h00;
    run_prog("restart", 1'b0, 1'b0, 2'd0, 8'd0);

    // PROG_LEN = 2 instance: implicit halt after pc=1, no wrap
    sel1 = 1'b1;
    plen = 2;
    do_reset();
    preload(2'd0, 8'd5);
    preload(2'd1, 8'd3);
    prog[0] = 8'h03; prog[1] = 8'h03;
    run_prog("len2", 1'b0, 1'b0, 2'd0, 8'd0);
    dump_regs();
    for (int t = 0; t < 6; t++) begin
      preload(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      random_prog(1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
